// File: rtl/obi_data_responder.sv
`timescale 1ns/1ps
// obi_data_responder
// Memory-backed far end of an OBI-style data port (req/gnt/rvalid).
// Grants are combinational, subject to a stall input and an outstanding limit.
// Byte-enabled writes land in a word array on the grant edge. Reads sample the
// array on that same edge. Each granted access produces one in-order response
// RESP_LATENCY cycles later. Out-of-range accesses return err=1 and rdata=0.
module obi_data_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int RESP_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        gnt_stall_i,
    output logic [3:0]  outstanding_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = 4;

    // Word storage. Reset does not touch it, so writes that were granted
    // before a reset survive it.
    logic [31:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  gnt;
    logic                  rvalid;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      cnt_eff;

    // Registered read word and the stage-0 flags loaded on a grant
    logic [31:0] rd_word_q;
    logic        s0_valid_q;
    logic        s0_err_q;
    logic        s0_read_q;

    // Stage view of the response pipeline; stage 0 is loaded by a grant,
    // the last stage drives the outputs
    logic [RESP_LATENCY-1:0]       st_valid;
    logic [RESP_LATENCY-1:0]       st_err;
    logic [RESP_LATENCY-1:0][31:0] st_rdata;

    // Byte-offset bits of the address are not used by a word-wide array
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_addr_i[1:0];

    assign word_idx = data_addr_i[ADDR_WIDTH+1:2];
    assign in_range = (data_addr_i[31:ADDR_WIDTH+2] == '0);

    // The response retiring this cycle frees its slot in this same cycle.
    // The registered counter only drops on the next edge, so subtract it here
    // to let grant reassert in the retire cycle.
    assign cnt_eff = cnt_q - CNT_W'(rvalid);
    assign gnt     = data_req_i & ~gnt_stall_i & ~rst_i
                   & (cnt_eff < CNT_W'(MAX_OUTSTANDING));

    assign data_gnt_o = gnt;

    // Byte-enabled write on the grant edge; out-of-range writes are dropped
    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered array read; sees the contents before any write on this edge
    always_ff @(posedge clk_i) begin
        if (gnt && !data_we_i && in_range) begin
            rd_word_q <= mem_q[word_idx];
        end
    end

    // Stage-0 flags: valid on any grant, err for out-of-range, read for data return
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s0_read_q  <= 1'b0;
        end else begin
            s0_valid_q <= gnt;
            s0_err_q   <= gnt & ~in_range;
            s0_read_q  <= gnt & ~data_we_i & in_range;
        end
    end

    // Stage 0 returns the read word only for in-range reads, zero otherwise
    assign st_valid[0] = s0_valid_q;
    assign st_err[0]   = s0_err_q;
    assign st_rdata[0] = s0_read_q ? rd_word_q : 32'h0;

    // Remaining stages form a plain shift register that never stalls
    for (genvar gi = 1; gi < RESP_LATENCY; gi++) begin : g_stage
        logic        valid_q;
        logic        err_q;
        logic [31:0] rdata_q;

        // Shift one stage per cycle; reset drops everything in flight
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                rdata_q <= 32'h0;
            end else begin
                valid_q <= st_valid[gi-1];
                err_q   <= st_err[gi-1];
                rdata_q <= st_rdata[gi-1];
            end
        end

        assign st_valid[gi] = valid_q;
        assign st_err[gi]   = err_q;
        assign st_rdata[gi] = rdata_q;
    end

    assign rvalid        = st_valid[RESP_LATENCY-1];
    assign data_rvalid_o = rvalid;
    assign data_err_o    = st_err[RESP_LATENCY-1];
    assign data_rdata_o  = st_rdata[RESP_LATENCY-1];

    // Outstanding count: +1 on grant, -1 on retire, unchanged when both happen
    always_comb begin
        cnt_d = cnt_q;
        case ({gnt, rvalid})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_obi_data_responder.sv
`timescale 1ns/1ps
// Bench for obi_data_responder: three instances with different latencies,
// one selected at a time, checked by a model memory plus response scoreboard.
module tb_obi_data_responder;

    localparam int N = 3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          sel;

    logic [N-1:0] req_v;
    logic [N-1:0] gnt_v;
    logic [N-1:0] rvalid_v;
    logic [N-1:0] err_v;
    logic [31:0]  rdata_v [N];
    logic [3:0]   outs_v  [N];

    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  outs;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          resp_cnt = 0;
    logic        mon_en   = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    assign req_v[0] = req && (sel == 0);
    assign req_v[1] = req && (sel == 1);
    assign req_v[2] = req && (sel == 2);

    assign gnt    = gnt_v[sel];
    assign rvalid = rvalid_v[sel];
    assign err    = err_v[sel];
    assign rdata  = rdata_v[sel];
    assign outs   = outs_v[sel];

    obi_data_responder #(.ADDR_WIDTH(10), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req_v[0]), .data_gnt_o(gnt_v[0]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid_v[0]), .data_rdata_o(rdata_v[0]), .data_err_o(err_v[0]),
        .gnt_stall_i(stall), .outstanding_o(outs_v[0])
    );

    obi_data_responder #(.ADDR_WIDTH(10), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req_v[1]), .data_gnt_o(gnt_v[1]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid_v[1]), .data_rdata_o(rdata_v[1]), .data_err_o(err_v[1]),
        .gnt_stall_i(stall), .outstanding_o(outs_v[1])
    );

    obi_data_responder #(.ADDR_WIDTH(10), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req_v[2]), .data_gnt_o(gnt_v[2]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid_v[2]), .data_rdata_o(rdata_v[2]), .data_err_o(err_v[2]),
        .gnt_stall_i(stall), .outstanding_o(outs_v[2])
    );

    function automatic int lat_of(input int s);
        if (s == 0) return 1;
        if (s == 1) return 4;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event (cycle %0d)", tag, cyc);
    endtask

    // Monitor: counter vs scoreboard depth, response pop/compare, expectation push
    always @(negedge clk) begin
        if (mon_en) begin
            check("outstanding_vs_inflight", 32'(outs), 32'(sb_q.size()));
            check("outstanding_le_max", 32'(outs <= 4'd2), 32'd1);
            if (rst) begin
                sb_q.delete();
            end else begin
                if (rvalid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL unexpected_rvalid observed=1 expected=0 (cycle %0d)", cyc);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("resp_rdata", rdata, e.rdata);
                        check("resp_err", 32'(err), 32'(e.err));
                        check("resp_cycle", 32'(cyc), 32'(e.cyc));
                        $display("resp sel=%0d cyc=%0d rdata=%h err=%0d", sel, cyc, rdata, err);
                    end
                    last_rdata = rdata;
                    last_err   = err;
                    resp_cnt++;
                end else begin
                    check("idle_rdata_zero", rdata, 32'h0);
                    check("idle_err_zero", 32'(err), 32'h0);
                end
                if (gnt) begin
                    exp_t e;
                    int   k;
                    logic [31:0] w;
                    k = sel * 65536 + int'(addr[11:2]);
                    e.cyc = cyc + lat_of(sel);
                    if (addr[31:12] != 20'h0) begin
                        e.err = 1'b1;
                        e.rdata = 32'h0;
                    end else if (we) begin
                        w = model_mem.exists(k) ? model_mem[k] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                        end
                        model_mem[k] = w;
                        e.err = 1'b0;
                        e.rdata = 32'h0;
                    end else begin
                        e.err = 1'b0;
                        e.rdata = model_mem.exists(k) ? model_mem[k] : 32'h0;
                    end
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic do_op(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int gc);
        we = w; addr = a; be = b; wdata = d; req = 1'b1;
        gc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) timeout_fail("grant_timeout");
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, n, base_resp;
        logic exp_g;
        rst = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0;
        addr = 32'h0; wdata = 32'h0; be = 4'h0; sel = 0;

        // Reset state, including a request held during reset
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        req = 1'b1;
        @(negedge clk);
        check("gnt_in_reset", 32'(gnt), 32'h0);
        for (int k = 0; k < N; k++) begin
            check("reset_rvalid", 32'(rvalid_v[k]), 32'h0);
            check("reset_rdata", rdata_v[k], 32'h0);
            check("reset_err", 32'(err_v[k]), 32'h0);
            check("reset_outstanding", 32'(outs_v[k]), 32'h0);
        end
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b0;

        // Write then read back, back-to-back, latency 1
        do_op(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, g0);
        do_op(1'b0, 32'h40, 4'h0, 32'h0, g1);
        check("back_to_back_grant", 32'(g1), 32'(g0 + 1));
        wait_idle();
        check("rd_deadbeef", last_rdata, 32'hDEADBEEF);
        check("rd_deadbeef_err", 32'(last_err), 32'h0);

        // Partial byte enables over an all-ones word
        do_op(1'b1, 32'h80, 4'hF, 32'hFFFFFFFF, g0);
        do_op(1'b1, 32'h80, 4'b0101, 32'h11223344, g0);
        do_op(1'b0, 32'h80, 4'h0, 32'h0, g0);
        wait_idle();
        check("byte_enable_merge", last_rdata, 32'hFF22FF44);

        // be=0 write responds but changes nothing
        do_op(1'b1, 32'h80, 4'h0, 32'h0, g0);
        do_op(1'b0, 32'h80, 4'h0, 32'h0, g0);
        wait_idle();
        check("be_zero_no_change", last_rdata, 32'hFF22FF44);

        // Out-of-range read and write; aliasing word stays untouched
        do_op(1'b0, 32'h0001_0000, 4'h0, 32'h0, g0);
        wait_idle();
        check("oor_err", 32'(last_err), 32'h1);
        check("oor_rdata", last_rdata, 32'h0);
        do_op(1'b1, 32'h0001_0040, 4'hF, 32'h12345678, g0);
        do_op(1'b0, 32'h40, 4'h0, 32'h0, g0);
        wait_idle();
        check("oor_array_unchanged", last_rdata, 32'hDEADBEEF);

        // Outstanding limit with latency 4: fill six words, then six held reads
        sel = 1;
        for (int k = 0; k < 6; k++) begin
            do_op(1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k), g0);
        end
        wait_idle();
        base_resp = resp_cnt;
        n = 0;
        we = 1'b0; addr = 32'h100; req = 1'b1;
        for (int c = 0; c < 20 && n < 6; c++) begin
            @(negedge clk);
            exp_g = (c == 0 || c == 1 || c == 4 || c == 5 || c == 8 || c == 9);
            check("limit_gnt_pattern", 32'(gnt), 32'(exp_g));
            if (gnt) n++;
            @(posedge clk); #1;
            if (n == 6) req = 1'b0;
            else addr = 32'h100 + 32'(4 * n);
        end
        req = 1'b0;
        check("limit_grant_count", 32'(n), 32'd6);
        wait_idle();
        check("limit_resp_count", 32'(resp_cnt - base_resp), 32'd6);
        check("limit_last_rdata", last_rdata, 32'hA000_0005);

        // Stall for three cycles while an earlier read is in flight
        do_op(1'b0, 32'h100, 4'h0, 32'h0, g0);
        stall = 1'b1; we = 1'b0; addr = 32'h104; req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_gnt_low", 32'(gnt), 32'h0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle();
        check("stall_last_rdata", last_rdata, 32'hA000_0001);

        // Reset mid-flight with latency 3
        sel = 2;
        do_op(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, g0);
        do_op(1'b0, 32'h200, 4'h0, 32'h0, g1);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h200;
        @(negedge clk);
        check("gnt_in_midreset", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_reset_rvalid", 32'(rvalid), 32'h0);
            check("post_reset_outstanding", 32'(outs), 32'h0);
            @(posedge clk); #1;
        end
        do_op(1'b0, 32'h200, 4'h0, 32'h0, g0);
        wait_idle();
        check("write_survives_reset", last_rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
